// File: rtl/name_stream_loader.sv
// Streams NDN name words into a small ring of name slots and hands complete,
// zero-masked names to the FIB lookup pipeline over a valid/ready handshake.
module name_stream_loader #(
    parameter int          WORD_SIZE       = 64,
    parameter int          MAX_NAME_LENGTH = 16,
    parameter int          NUM_SLOTS       = 2,
    parameter bit          USE_SENTINEL    = 1'b1,
    parameter logic [63:0] SENTINEL        = 64'h7B7B7D7D,
    parameter int          LEN_W           = $clog2(MAX_NAME_LENGTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WORD_SIZE-1:0]                 in_word,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] out_name,
    output logic [LEN_W-1:0]                     out_len,
    output logic                                 out_trunc,
    output logic [15:0]                          trunc_count
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int IDX_W = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1;
    localparam logic [WORD_SIZE-1:0] SENT_WORD = WORD_SIZE'(SENTINEL);
    localparam logic [LEN_W-1:0]     MAX_LEN   = LEN_W'(MAX_NAME_LENGTH);
    localparam logic [PTR_W-1:0]     LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

    localparam logic [1:0] SLOT_EMPTY   = 2'd0;
    localparam logic [1:0] SLOT_FILLING = 2'd1;
    localparam logic [1:0] SLOT_FULL    = 2'd2;

    localparam logic FILL_IDLE = 1'b0;
    localparam logic FILL_BUSY = 1'b1;

    logic [1:0]           slot_state [NUM_SLOTS];
    logic [LEN_W-1:0]     slot_len   [NUM_SLOTS];
    logic                 slot_trunc [NUM_SLOTS];
    logic [WORD_SIZE-1:0] slot_ram   [NUM_SLOTS][MAX_NAME_LENGTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LEN_W-1:0] word_cnt;
    logic             fill_state;
    logic             cur_trunc;

    logic             in_fire;
    logic             out_fire;
    logic             is_sentinel;
    logic             name_end;
    logic             has_room;
    logic             store_word;
    logic             drop_word;
    logic [LEN_W-1:0] next_len;
    logic             rd_full;

    // Handshake: a word moves on in_valid & in_ready, a name on out_valid & out_ready,
    // both at the rising edge; in_ready depends only on registered slot state.
    assign in_ready    = ~rst & (slot_state[wr_ptr] != SLOT_FULL);
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign is_sentinel = USE_SENTINEL && (in_word == SENT_WORD);
    assign name_end    = in_last | is_sentinel;
    assign has_room    = word_cnt < MAX_LEN;
    assign store_word  = in_fire & ~is_sentinel & has_room;
    assign drop_word   = in_fire & ~is_sentinel & ~has_room;
    assign next_len    = word_cnt + LEN_W'(store_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_state[s] <= SLOT_EMPTY;
                slot_len[s]   <= '0;
                slot_trunc[s] <= 1'b0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_cnt    <= '0;
            fill_state  <= FILL_IDLE;
            cur_trunc   <= 1'b0;
            trunc_count <= '0;
        end else begin
            if (in_fire) begin
                if (name_end) begin
                    slot_state[wr_ptr] <= SLOT_FULL;
                    slot_len[wr_ptr]   <= next_len;
                    slot_trunc[wr_ptr] <= cur_trunc | drop_word;
                    wr_ptr             <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
                    word_cnt           <= '0;
                    cur_trunc          <= 1'b0;
                    fill_state         <= FILL_IDLE;
                end else begin
                    if (fill_state == FILL_IDLE) begin
                        slot_state[wr_ptr] <= SLOT_FILLING;
                        fill_state         <= FILL_BUSY;
                    end
                    word_cnt  <= next_len;
                    cur_trunc <= cur_trunc | drop_word;
                end
            end
            // A completing slot is never FULL beforehand, so it cannot be the popped slot.
            if (out_fire) begin
                slot_state[rd_ptr] <= SLOT_EMPTY;
                rd_ptr             <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
                if (slot_trunc[rd_ptr] && (trunc_count != 16'hFFFF)) begin
                    trunc_count <= trunc_count + 16'd1;
                end
            end
        end
    end

    // Word storage is never cleared; stale words are masked on the output side.
    always_ff @(posedge clk) begin
        if (store_word) begin
            slot_ram[wr_ptr][word_cnt[IDX_W-1:0]] <= in_word;
        end
    end

    assign rd_full   = (slot_state[rd_ptr] == SLOT_FULL);
    assign out_valid = rd_full;
    assign out_len   = rd_full ? slot_len[rd_ptr] : '0;
    assign out_trunc = rd_full & slot_trunc[rd_ptr];

    always_comb begin
        out_name = '0;
        for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
            if (rd_full && (LEN_W'(i) < slot_len[rd_ptr])) begin
                out_name[i*WORD_SIZE +: WORD_SIZE] = slot_ram[rd_ptr][i];
            end
        end
    end

endmodule

// File: tb/tb_name_stream_loader.sv
// Bench for name_stream_loader: directed scenarios plus random names, checked
// against a word-list model of name assembly and an expected-name queue.
module tb_name_stream_loader;

    localparam int W      = 64;
    localparam int MAXL   = 16;
    localparam int NS     = 2;
    localparam int LEN_W  = 5;
    localparam int NAME_W = W * MAXL;
    localparam int EW     = 1 + LEN_W + NAME_W;
    localparam logic [W-1:0] SENT = 64'h7B7B7D7D;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_word = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NAME_W-1:0] out_name;
    logic [LEN_W-1:0]  out_len;
    logic              out_trunc;
    logic [15:0]       trunc_count;

    name_stream_loader #(
        .WORD_SIZE(W), .MAX_NAME_LENGTH(MAXL), .NUM_SLOTS(NS),
        .USE_SENTINEL(1'b1), .SENTINEL(64'h7B7B7D7D), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_name(out_name),
        .out_len(out_len), .out_trunc(out_trunc), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  stim_q[$];
    bit            stim_last;
    int            exp_trunc = 0;
    int            pop_cyc[$];
    bit            rand_rdy = 0;
    logic [EW-1:0] mon_exp;

    // Scoreboard: every accepted output is compared with the oldest expected name.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got name len=%0d, required no output", out_len);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_len !== mon_exp[NAME_W +: LEN_W]) begin
                    errors++;
                    $display("FAIL out_len: got %0d, required %0d", out_len, mon_exp[NAME_W +: LEN_W]);
                end
                checks++;
                if (out_trunc !== mon_exp[EW-1]) begin
                    errors++;
                    $display("FAIL out_trunc: got %0b, required %0b", out_trunc, mon_exp[EW-1]);
                end
                checks++;
                if (out_name !== mon_exp[NAME_W-1:0]) begin
                    errors++;
                    $display("FAIL out_name: got %h, required %h", out_name, mon_exp[NAME_W-1:0]);
                end
                if (mon_exp[EW-1]) exp_trunc++;
            end
        end
    end

    // Reference: walk the word list, skip sentinels, keep the first MAXL words.
    function automatic logic [EW-1:0] model_name();
        logic [NAME_W-1:0] nm;
        int  len;
        bit  tr;
        bit  sent;
        bit  fin;
        nm  = '0;
        len = 0;
        tr  = 0;
        for (int j = 0; j < stim_q.size(); j++) begin
            sent = (stim_q[j] == SENT);
            fin  = sent || (stim_last && (j == stim_q.size() - 1));
            if (!sent) begin
                if (len < MAXL) begin
                    nm[len*W +: W] = stim_q[j];
                    len++;
                end else begin
                    tr = 1;
                end
            end
            if (fin) break;
        end
        return {tr, LEN_W'(len), nm};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = {$urandom, $urandom};
        if (w == SENT) w = w + 1;
        return w;
    endfunction

    task automatic send_stim();
        int guard;
        bit acc;
        for (int j = 0; j < stim_q.size(); j++) begin
            in_valid = 1'b1;
            in_word  = stim_q[j];
            in_last  = stim_last && (j == stim_q.size() - 1);
            acc   = 0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
                guard++;
                if (!acc && guard > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", guard);
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic queue_name();
        exp_q.push_back(model_name());
        send_stim();
    endtask

    task automatic drain();
        int g;
        out_ready = 1'b1;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d names left, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: out_valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b, required 0", in_ready); end
        checks++; if (out_len !== '0) begin errors++; $display("FAIL rst_out_len: got %0d, required 0", out_len); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL rst_out_trunc: got %0b, required 0", out_trunc); end
        checks++; if (out_name !== '0) begin errors++; $display("FAIL rst_out_name: got %h, required 0", out_name); end
        checks++; if (trunc_count !== 16'd0) begin errors++; $display("FAIL rst_trunc_count: got %0d, required 0", trunc_count); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %0b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        stim_q.delete();
        for (int k = 1; k <= 3; k++) stim_q.push_back(W'(k));
        stim_last = 1;
        queue_name();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%0b, required 1", out_valid); end
        checks++; if (out_len !== 5'd3) begin errors++; $display("FAIL basic_len: got %0d, required 3", out_len); end
        drain();
    endtask

    task automatic test_sentinel();
        out_ready = 1'b1;
        stim_q.delete();
        stim_q.push_back(64'hA);
        stim_q.push_back(64'hB);
        stim_q.push_back(SENT);
        stim_last = 0;
        queue_name();
        drain();
        stim_q.delete();
        stim_q.push_back(SENT);
        stim_last = 0;
        queue_name();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lone_sent_valid: got %0b, required 1", out_valid); end
        checks++; if (out_name !== '0) begin errors++; $display("FAIL lone_sent_name: got %h, required 0", out_name); end
        drain();
        stim_q.delete();
        stim_q.push_back(SENT);
        stim_last = 1;
        queue_name();
        stim_q.delete();
        stim_q.push_back(64'h7);
        stim_last = 1;
        queue_name();
        drain();
    endtask

    task automatic test_trunc();
        out_ready = 1'b1;
        stim_q.delete();
        for (int k = 1; k <= 20; k++) stim_q.push_back(W'(k));
        stim_last = 1;
        queue_name();
        drain();
        checks++;
        if (trunc_count !== 16'(exp_trunc)) begin
            errors++;
            $display("FAIL trunc_count: got %0d, required %0d", trunc_count, exp_trunc);
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] head;
        out_ready = 1'b0;
        stim_last = 1;
        stim_q.delete(); stim_q.push_back(64'h11); stim_q.push_back(64'h12);
        queue_name();
        stim_q.delete(); stim_q.push_back(64'h21); stim_q.push_back(64'h22);
        queue_name();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %0b, required 0", in_ready); end
        head = exp_q[0];
        in_valid = 1'b1;
        in_word  = 64'h31;
        in_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_in_ready: got %0b, required 0", in_ready); end
            checks++; if (out_name !== head[NAME_W-1:0]) begin errors++; $display("FAIL bp_stable_name: got %h, required %h", out_name, head[NAME_W-1:0]); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable_valid: got %0b, required 1", out_valid); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_in_ready: got %0b, required 1", in_ready); end
        stim_q.delete(); stim_q.push_back(64'h31); stim_q.push_back(64'h32);
        queue_name();
        drain();
    endtask

    task automatic test_back_to_back();
        int c0;
        out_ready = 1'b1;
        pop_cyc.delete();
        c0 = cyc;
        stim_last = 1;
        for (int k = 0; k < 8; k++) begin
            stim_q.delete();
            stim_q.push_back(rand_word());
            queue_name();
        end
        checks++;
        if (cyc - c0 != 8) begin
            errors++;
            $display("FAIL b2b_in_cycles: got %0d, required 8", cyc - c0);
        end
        drain();
        checks++;
        if (pop_cyc.size() != 8 || pop_cyc[pop_cyc.size()-1] - pop_cyc[0] != 7) begin
            errors++;
            $display("FAIL b2b_out_span: got %0d pops, required 8 in 8 consecutive cycles", pop_cyc.size());
        end
    endtask

    task automatic test_random();
        int n;
        int mode;
        rand_rdy = 1;
        for (int k = 0; k < 25; k++) begin
            n    = $urandom_range(0, 20);
            mode = $urandom_range(0, 2);
            if (n == 0 && mode == 0) mode = 1;
            stim_q.delete();
            for (int j = 0; j < n; j++) stim_q.push_back(rand_word());
            if (mode != 0) stim_q.push_back(SENT);
            stim_last = (mode != 1);
            queue_name();
        end
        rand_rdy = 0;
        drain();
        checks++;
        if (trunc_count !== 16'(exp_trunc)) begin
            errors++;
            $display("FAIL rand_trunc_count: got %0d, required %0d", trunc_count, exp_trunc);
        end
    endtask

    task automatic test_reset_midname();
        out_ready = 1'b0;
        stim_last = 1;
        stim_q.delete(); stim_q.push_back(64'h55);
        send_stim();
        stim_last = 0;
        stim_q.delete(); stim_q.push_back(64'h66); stim_q.push_back(64'h67);
        send_stim();
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %0b, required 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %0b, required 0", in_ready); end
        exp_trunc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_in_ready: got %0b, required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rel_out_valid: got %0b, required 0", out_valid); end
        checks++; if (trunc_count !== 16'd0) begin errors++; $display("FAIL mid_rel_trunc_count: got %0d, required 0", trunc_count); end
        out_ready = 1'b1;
        stim_last = 1;
        stim_q.delete(); stim_q.push_back(64'h5); stim_q.push_back(64'h6);
        queue_name();
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sentinel();
        test_trunc();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midname();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/name_stream_loader.md
Name: name_stream_loader

Overview:
- Parametrised successor to the file-driven name feeder.
- Accepts an NDN name as a stream of WORD_SIZE words, each name terminated by in_last or by a sentinel word. Assembles the words into a zero-padded name vector.
- Buffers up to NUM_SLOTS complete names so the next name can load while the FIB lookup pipeline holds the current one.
- Delivers names to the lookup pipeline (top) over a valid/ready handshake.

Parameters:
WORD_SIZE, 64, bits per name word
MAX_NAME_LENGTH, 16, max words per name; words beyond this are dropped
NUM_SLOTS, 2, number of name buffers (>=1)
USE_SENTINEL, 1, 1 = a word equal to SENTINEL also terminates a name
SENTINEL, 64'h7B7B7D7D ("{{}}"), terminator word value, zero-extended to WORD_SIZE
LEN_W, $clog2(MAX_NAME_LENGTH+1), derived; width of length fields

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  in_word valid
in_ready  out  1  block accepts in_word this cycle
in_word  in  WORD_SIZE  name word
in_last  in  1  in_word is the final word of the name
out_valid  out  1  complete name available
out_ready  in  1  consumer takes name this cycle
out_name  out  WORD_SIZE*MAX_NAME_LENGTH  word i at [i*WORD_SIZE +: WORD_SIZE]; words >= out_len read 0
out_len  out  LEN_W  stored word count, 0..MAX_NAME_LENGTH
out_trunc  out  1  name exceeded MAX_NAME_LENGTH and was truncated
trunc_count  out  16  saturating count of truncated names emitted

Behaviour:
- Transfers: input on in_valid&in_ready; output on out_valid&out_ready; both at the rising clk edge.
- Reset (async assert, sync release):
  - All slots EMPTY, fill state IDLE, write/read pointers 0, word counter 0, trunc_count 0.
  - out_valid=0, out_len=0, out_trunc=0, out_name=0.
  - in_ready=0 while rst=1.
- Slot state is EMPTY -> FILLING -> FULL -> EMPTY.
  - FILLING slot = slot at write pointer.
  - FULL slots are popped in order from the read pointer.
- in_ready=1 iff the write-pointer slot is not FULL. It is a function of registered state only, with no combinational path from out_ready.
- Fill FSM:
  - IDLE: first accepted word moves the slot to FILLING.
  - FILLING: each accepted word is stored at index = word counter while counter < MAX_NAME_LENGTH, and the counter increments.
    - A word arriving with counter == MAX_NAME_LENGTH is dropped and sets the slot's trunc flag.
  - End of name = accepted word with in_last=1, or (USE_SENTINEL and in_word==SENTINEL). On end of name:
    - The sentinel word itself is never stored.
    - A non-sentinel in_last word is stored, subject to the length limit.
    - Slot becomes FULL with its len/trunc; write pointer advances modulo NUM_SLOTS; counter clears; FSM returns to IDLE.
  - A sentinel with in_last=1 ends the name once; it is not stored.
  - A lone sentinel or sentinel-as-first-word completes an empty name: out_len=0, out_name all zero.
- Latency: name completed at edge N gives out_valid=1 from edge N (registered; visible in cycle N+1). Min 1 cycle from end word to out_valid.
- Output:
  - out_valid=1 iff the read-pointer slot is FULL. out_name/out_len/out_trunc come from that slot and are stable while out_valid=1 and out_ready=0.
  - Pop: slot becomes EMPTY, read pointer advances.
  - Zero-fill is done by masking words at index >= out_len; slot RAM is not cleared.
- Simultaneous pop and complete on the same edge are both honoured. When all slots are FULL, a pop frees a slot and in_ready rises the next cycle.
- trunc_count increments on pop of a slot with trunc=1 and saturates at 16'hFFFF.
- A partial name in FILLING is discarded on reset, and no output is produced for it.

Test Plan:
- Words 1,2,3 (in_last on 3), out_ready=1 -> one cycle later out_valid=1, out_len=3, words 0..2 = 1,2,3, words 3..15 = 0, out_trunc=0.
- Words 0xA, 0xB then 64'h7B7B7D7D, no in_last -> out_len=2, words 0xA,0xB; sentinel not stored. A lone sentinel -> out_len=0, out_name=0.
- 20 words, values 1..20, in_last on 20 -> out_len=16, words 1..16, out_trunc=1; after pop, trunc_count=1.
- out_ready=0, stream 3 names of 2 words each, NUM_SLOTS=2 -> in_ready falls after the 2nd name completes. Third name's first word stalls; outputs stay stable. One pop -> in_ready=1 the next cycle. Order of names out = order in.
- Continuous back-to-back 1-word names with out_ready=1 -> one name per cycle sustained, no bubbles after the first.
- Assert rst after 2 words of a name, while one FULL name waits -> out_valid=0 and in_ready=0 during reset. After release, in_ready=1, out_valid=0, trunc_count=0, and the next name loads from index 0.
